// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU sequencer: opcodes, FSM states,
// the decoded-instruction payload and the conditional-jump helper.
package cpu_pkg;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_ADD = 4'h2;
  localparam logic [OPW-1:0] OP_SUB = 4'h3;
  localparam logic [OPW-1:0] OP_AND = 4'h4;
  localparam logic [OPW-1:0] OP_STA = 4'h5;
  localparam logic [OPW-1:0] OP_JMP = 4'h6;
  localparam logic [OPW-1:0] OP_JZ  = 4'h7;
  localparam logic [OPW-1:0] OP_JN  = 4'h8;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_OF   = 3'd2,
    S_MR   = 3'd3,
    S_EX   = 3'd4,
    S_ST   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_AND  = 2'd3
  } alu_sel_t;

  typedef enum logic [1:0] {
    JC_NONE   = 2'd0,
    JC_ALWAYS = 2'd1,
    JC_Z      = 2'd2,
    JC_N      = 2'd3
  } jmp_cond_t;

  typedef struct packed {
    logic      one_byte;
    logic      halt;
    logic      alu_op;
    logic      store;
    logic      jump;
    jmp_cond_t cond;
    alu_sel_t  alu_sel;
  } dec_t;

  // Resolve a jump condition against the ALU flags.
  function automatic logic jump_taken(input jmp_cond_t cond, input logic z, input logic n);
    logic taken;
    case (cond)
      JC_ALWAYS: taken = 1'b1;
      JC_Z:      taken = z;
      JC_N:      taken = n;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Opcode classifier: maps a 4-bit opcode to its instruction class and ALU enable.
import cpu_pkg::*;

module cpu_decode (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec_c
);

  always_comb begin
    dec_c.one_byte = 1'b0;
    dec_c.halt     = 1'b0;
    dec_c.alu_op   = 1'b0;
    dec_c.store    = 1'b0;
    dec_c.jump     = 1'b0;
    dec_c.cond     = JC_NONE;
    dec_c.alu_sel  = ALU_PASS;
    case (opcode)
      OP_LDA: begin
        dec_c.alu_op  = 1'b1;
        dec_c.alu_sel = ALU_PASS;
      end
      OP_ADD: begin
        dec_c.alu_op  = 1'b1;
        dec_c.alu_sel = ALU_ADD;
      end
      OP_SUB: begin
        dec_c.alu_op  = 1'b1;
        dec_c.alu_sel = ALU_SUB;
      end
      OP_AND: begin
        dec_c.alu_op  = 1'b1;
        dec_c.alu_sel = ALU_AND;
      end
      OP_STA: dec_c.store = 1'b1;
      OP_JMP: begin
        dec_c.jump = 1'b1;
        dec_c.cond = JC_ALWAYS;
      end
      OP_JZ: begin
        dec_c.jump = 1'b1;
        dec_c.cond = JC_Z;
      end
      OP_JN: begin
        dec_c.jump = 1'b1;
        dec_c.cond = JC_N;
      end
      OP_HLT: begin
        dec_c.one_byte = 1'b1;
        dec_c.halt     = 1'b1;
      end
      // OP_NOP and the undefined opcodes 9-E all behave as a one-byte no-op
      default: dec_c.one_byte = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the accumulator CPU: fetch/decode/operand FSM driving
// the memory strobes, the ALU enables and the ALU operand bus.
import cpu_pkg::*;

module cpu_ctrl (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] acc,
  input  logic          z_flag,
  input  logic          n_flag,
  output logic          alu_en,
  output logic          alu_add,
  output logic          alu_sub,
  output logic          alu_and,
  output logic          alu_pass,
  output logic [DW-1:0] alu_din,
  output logic [AW-1:0] pc,
  output logic          halted
);

  state_t         state, state_nxt;
  logic [AW-1:0]  pc_q, pc_nxt;
  logic [AW-1:0]  opr, opr_nxt;
  // Only the opcode nibble of the instruction register is ever consulted
  logic [OPW-1:0] ir_op, ir_op_nxt;
  logic [OPW-1:0] dec_op;
  dec_t           dec;

  // In S_ID the opcode is decoded straight off the memory bus, later from ir
  assign dec_op = (state == S_ID) ? mem_rdata[DW-1:DW-OPW] : ir_op;

  cpu_decode u_decode (
    .opcode (dec_op),
    .dec_c  (dec)
  );

  assign pc        = pc_q;
  assign mem_wdata = acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
      pc_q  <= '0;
      ir_op <= '0;
      opr   <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_op <= ir_op_nxt;
      opr   <= opr_nxt;
    end
  end

  // Next-state, register updates and state-decoded outputs
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_op_nxt = ir_op;
    opr_nxt   = opr;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    alu_en    = 1'b0;
    alu_add   = 1'b0;
    alu_sub   = 1'b0;
    alu_and   = 1'b0;
    alu_pass  = 1'b0;
    alu_din   = '0;
    halted    = 1'b0;

    case (state)
      S_IF: begin
        mem_addr = pc_q;
        if (!hold) begin
          // Fetch strobe stays low while reset is asserted
          mem_re    = reset;
          pc_nxt    = pc_q + AW'(1);
          state_nxt = S_ID;
        end
      end

      S_ID: begin
        ir_op_nxt = mem_rdata[DW-1:DW-OPW];
        if (dec.halt) begin
          state_nxt = S_HALT;
        end else if (dec.one_byte) begin
          state_nxt = S_IF;
        end else begin
          mem_addr  = pc_q;
          mem_re    = 1'b1;
          pc_nxt    = pc_q + AW'(1);
          state_nxt = S_OF;
        end
      end

      S_OF: begin
        opr_nxt = mem_rdata;
        if (dec.jump) begin
          if (jump_taken(dec.cond, z_flag, n_flag)) begin
            pc_nxt = mem_rdata;
          end
          state_nxt = S_IF;
        end else if (dec.store) begin
          state_nxt = S_ST;
        end else if (dec.alu_op) begin
          state_nxt = S_MR;
        end else begin
          state_nxt = S_IF;
        end
      end

      S_MR: begin
        mem_addr  = opr;
        mem_re    = 1'b1;
        state_nxt = S_EX;
      end

      S_EX: begin
        alu_en  = 1'b1;
        alu_din = mem_rdata;
        case (dec.alu_sel)
          ALU_ADD: alu_add  = 1'b1;
          ALU_SUB: alu_sub  = 1'b1;
          ALU_AND: alu_and  = 1'b1;
          default: alu_pass = 1'b1;
        endcase
        state_nxt = S_IF;
      end

      S_ST: begin
        mem_addr  = opr;
        mem_we    = 1'b1;
        state_nxt = S_IF;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a behavioural synchronous memory and accumulator ALU.
module tb_cpu_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hold  = 1'b0;
  logic [7:0] mem_addr, mem_rdata, mem_wdata, acc, alu_din, pc;
  logic       mem_re, mem_we, z_flag, n_flag;
  logic       alu_en, alu_add, alu_sub, alu_and, alu_pass, halted;

  logic [7:0] mem [256];
  logic       ld_clr = 1'b0;
  logic       ld_en  = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;
  logic [7:0] alu_r;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clock = ~clock;

  cpu_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .acc       (acc),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .alu_en    (alu_en),
    .alu_add   (alu_add),
    .alu_sub   (alu_sub),
    .alu_and   (alu_and),
    .alu_pass  (alu_pass),
    .alu_din   (alu_din),
    .pc        (pc),
    .halted    (halted)
  );

  // Synchronous 256x8 memory with a bench-side load port
  always @(posedge clock) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Accumulator ALU model
  always_comb begin
    alu_r = acc;
    if (alu_pass)     alu_r = alu_din;
    else if (alu_add) alu_r = acc + alu_din;
    else if (alu_sub) alu_r = acc - alu_din;
    else if (alu_and) alu_r = acc & alu_din;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= 8'h00;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (alu_en) begin
      acc    <= alu_r;
      z_flag <= (alu_r == 8'h00);
      n_flag <= alu_r[7];
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic begin_test();
    @(negedge clock);
    reset = 1'b0;
    hold  = 1'b0;
    ld_clr = 1'b1;
    @(posedge clock);
    #1;
    ld_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clock);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // LDA/ADD/STA/HLT program
    begin_test();
    load(8'h00, 8'h10); load(8'h01, 8'h20); load(8'h02, 8'h20); load(8'h03, 8'h21);
    load(8'h04, 8'h50); load(8'h05, 8'h22); load(8'h06, 8'hF0);
    load(8'h20, 8'h05); load(8'h21, 8'h03);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", {7'd0, halted}, 8'h00);
    check("rst_strobes", {6'd0, mem_re, mem_we}, 8'h00);
    check("rst_alu_en", {3'd0, alu_en, alu_add, alu_sub, alu_and, alu_pass}, 8'h00);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_alu_din", alu_din, 8'h00);
    release_reset();
    check("if_fetch", {7'd0, mem_re}, 8'h01);
    tick(4);
    check("lda_ex_enables", {3'd0, alu_en, alu_add, alu_sub, alu_and, alu_pass}, 8'h11);
    check("lda_ex_din", alu_din, 8'h05);
    tick(5);
    check("add_ex_enables", {3'd0, alu_en, alu_add, alu_sub, alu_and, alu_pass}, 8'h18);
    cnt = 9;
    while (!halted && cnt < 40) begin
      tick(1);
      cnt++;
    end
    check("cycles_to_halt", 8'(cnt), 8'd16);
    check("halt_pc", pc, 8'h07);
    check("sta_result", mem[8'h22], 8'h08);
    tick(3);
    check("halt_no_strobe", {6'd0, mem_re, mem_we}, 8'h00);
    check("halt_pc_stable", pc, 8'h07);

    // SUB to zero then JZ taken
    begin_test();
    load(8'h00, 8'h10); load(8'h01, 8'h20); load(8'h02, 8'h30); load(8'h03, 8'h21);
    load(8'h04, 8'h70); load(8'h05, 8'h40);
    load(8'h20, 8'h07); load(8'h21, 8'h07);
    release_reset();
    tick(13);
    check("jz_taken_pc", pc, 8'h40);

    // Unequal operands: JZ falls through
    begin_test();
    load(8'h00, 8'h10); load(8'h01, 8'h20); load(8'h02, 8'h30); load(8'h03, 8'h21);
    load(8'h04, 8'h70); load(8'h05, 8'h40);
    load(8'h20, 8'h07); load(8'h21, 8'h03);
    release_reset();
    tick(13);
    check("jz_fall_pc", pc, 8'h06);

    // JN not taken, then 0x01-0x02 sets n and JN is taken
    begin_test();
    load(8'h00, 8'h10); load(8'h01, 8'h20); load(8'h02, 8'h80); load(8'h03, 8'h40);
    load(8'h04, 8'h30); load(8'h05, 8'h21); load(8'h06, 8'h80); load(8'h07, 8'h40);
    load(8'h20, 8'h01); load(8'h21, 8'h02);
    release_reset();
    tick(8);
    check("jn_fall_pc", pc, 8'h04);
    tick(5);
    check("sub_acc", acc, 8'hFF);
    tick(3);
    check("jn_taken_pc", pc, 8'h40);

    // Undefined opcode and 0x00 as two-cycle NOPs
    begin_test();
    load(8'h00, 8'h90); load(8'h01, 8'h00); load(8'h02, 8'hF0);
    release_reset();
    tick(1);
    check("nop9_id_strobes", {5'd0, mem_re, mem_we, alu_en}, 8'h00);
    check("nop9_id_pc", pc, 8'h01);
    tick(1);
    check("nop9_next_fetch", {7'd0, mem_re}, 8'h01);
    check("nop9_next_addr", mem_addr, 8'h01);
    tick(1);
    check("nop0_id_strobes", {5'd0, mem_re, mem_we, alu_en}, 8'h00);
    tick(1);
    check("nop0_pc", pc, 8'h02);
    tick(2);
    check("nop_halted", {7'd0, halted}, 8'h01);
    check("nop_halt_pc", pc, 8'h03);

    // Operand fetch wraps from 0xFF to 0x00
    begin_test();
    load(8'h00, 8'h30); load(8'h01, 8'h21); load(8'h02, 8'h60); load(8'h03, 8'hFF);
    load(8'hFF, 8'h60); load(8'h21, 8'h01);
    release_reset();
    tick(8);
    check("wrap_jmp_pc", pc, 8'hFF);
    tick(1);
    check("wrap_pc_zero", pc, 8'h00);
    check("wrap_opr_addr", mem_addr, 8'h00);
    check("wrap_opr_re", {7'd0, mem_re}, 8'h01);
    tick(2);
    check("wrap_target_pc", pc, 8'h30);

    // hold freezes S_IF; reset during S_ST aborts the store
    begin_test();
    load(8'h00, 8'h50); load(8'h01, 8'h22); load(8'h22, 8'hAA);
    hold = 1'b1;
    release_reset();
    check("hold_re_low", {7'd0, mem_re}, 8'h00);
    tick(4);
    check("hold_pc", pc, 8'h00);
    check("hold_re_still_low", {7'd0, mem_re}, 8'h00);
    check("hold_addr", mem_addr, 8'h00);
    @(negedge clock);
    hold = 1'b0;
    #1;
    check("unhold_re", {7'd0, mem_re}, 8'h01);
    tick(1);
    @(negedge clock);
    hold = 1'b1;
    #1;
    check("hold_in_id_ignored", {7'd0, mem_re}, 8'h01);
    tick(1);
    check("hold_in_id_pc", pc, 8'h02);
    tick(1);
    check("st_we", {7'd0, mem_we}, 8'h01);
    check("st_addr", mem_addr, 8'h22);
    reset = 1'b0;
    #1;
    check("abort_we", {6'd0, mem_re, mem_we}, 8'h00);
    check("abort_pc", pc, 8'h00);
    check("abort_addr", mem_addr, 8'h00);
    check("abort_alu", {2'd0, halted, alu_en, alu_add, alu_sub, alu_and, alu_pass}, 8'h00);
    check("abort_din", alu_din, 8'h00);
    tick(2);
    check("abort_no_write", mem[8'h22], 8'hAA);
    @(negedge clock);
    hold  = 1'b0;
    reset = 1'b1;
    #1;
    check("restart_re", {7'd0, mem_re}, 8'h01);
    check("restart_addr", mem_addr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
